inst_asm_loader: RTL
====================

# inst_asm_loader

Sequential RV32I instruction assembler and instruction-memory loader, the encode-side counterpart of the core's control decoder. It accepts symbolic instruction commands (mnemonic code plus register and immediate fields) over a valid/ready handshake. It packs each command into a 32-bit RV32I word and streams the words into the instruction memory write port at consecutive word addresses. It sits beside the single-cycle core in the simulation top and preloads programs without hex files.

## Interface
- `AW`, default 12: instruction-memory byte-address width; the address wraps modulo 2^AW.
- `clk` input 1: rising-edge clock.
- `rstn` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle pulse that begins a load session; honoured only in IDLE.
- `base_addr` input AW: first byte address; sampled on `start`; bits [1:0] forced to 0.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_mn` input 5: mnemonic code. The codes are 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 addi, 11 xori, 12 ori, 13 andi, 14 slli, 15 srli, 16 srai, 17 slti, 18 sltiu, 19 lw, 20 sw, 21 beq, 22 bne, 23 blt, 24 bge, 25 bltu, 26 bgeu, 27 lui, 28 jal, 29 jalr. Codes 30 and 31 are illegal.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` input 5 each: register fields; a field is ignored when the format does not use it.
- `cmd_imm` input 32: the immediate.
  - B and J formats: signed byte offset.
  - U format: `cmd_imm[31:12]` is used.
  - Shifts: the shift amount is in `cmd_imm[4:0]`.
- `cmd_last` input 1: marks the final command of the session.
- `im_we` output 1: write request to instruction memory.
- `im_addr` output AW: byte address of the write.
- `im_wdata` output 32: encoded instruction.
- `im_wready` input 1: the memory accepts the write when `im_we && im_wready`.
- `count` output AW-1: number of words written in the current or last session.
- `done` output 1: one-cycle pulse when the session completes.
- `err` output 1: sticky encode error; cleared on `start`.

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE → RUN on `start`. This transition loads the address pointer with `base_addr` and clears `count` and `err`.
  - RUN → DRAIN when a command with `cmd_last=1` is accepted.
  - DRAIN → IDLE when the pending write completes; `done` pulses on that transition.
- `start` in RUN or DRAIN is ignored.
- `cmd_ready = (state==RUN) && (!im_we || im_wready)`. This forms a single-entry output register, so one command per cycle is sustained when the memory always accepts.
- Command acceptance:
  - On accept, the encoded word is registered into `im_wdata` and `im_we` is set.
  - On write completion, the pointer increments by 4 and `count` increments by 1.
  - When acceptance and completion happen in the same edge, `im_we` stays high and the new word replaces the old one.
- Encoding uses the standard RV32I opcode, funct3 and funct7 fields:
  - R: opcode 0110011. Bit 30 is set for sub and sra.
  - I-alu: opcode 0010011. srai sets bit 30.
  - lw: opcode 0000011, funct3 010.
  - sw: opcode 0100011, funct3 010.
  - B: opcode 1100011.
  - lui: opcode 0110111.
  - jal: opcode 1101111.
  - jalr: opcode 1100111, funct3 000.
  - B and J immediates are scattered exactly per the ISA, and imm[0] is dropped.
- With range checking disabled, out-of-range immediates are truncated to the field width.
- Reset mid-session: the FSM returns to IDLE and all state is cleared. Words already written remain in memory.

## Timing
- Reset values are: `cmd_ready` 0, `im_we` 0, `im_addr` 0, `im_wdata` 0, `count` 0, `done` 0, `err` 0, state IDLE.
- Accept at edge N → `im_we`/`im_wdata` valid after edge N. The write completes at the first edge ≥ N+1 with `im_wready` high.
- `done` is high for exactly the cycle after the last write completes.
- Address wrap: 2^AW−4 + 4 → 0, with no flag.
- Minimum session: `start` at edge S, accept at S+1, write at S+2, `done` high after S+2.

## Configuration
- `ASM_CHECK_EN` defined: an offending command is written as NOP 0x00000013 and sets `err`. A command offends when any of the following holds:
  - illegal mnemonic;
  - I/S immediate outside [−2048, 2047];
  - B immediate odd or outside [−4096, 4094];
  - J immediate odd or outside [−2^20, 2^20−2];
  - shift `cmd_imm[31:5]` ≠ 0;
  - lui `cmd_imm[11:0]` ≠ 0.
- Not defined: no checking. `err` is tied to 0 and illegal mnemonics encode as 0x00000000.

## Test plan
- `start`, `base_addr`=0x100, then add x3,x1,x2 and addi x1,x0,5 (`cmd_last`) with `im_wready`=1 → writes 0x002081B3 @0x100 and 0x00500093 @0x104; `count`=2; `done` pulses once.
- sw x2,8(x1); beq x1,x2,−4; jal x1,+8 → 0x0020A423, 0xFE208EE3, 0x008000EF.
- lui x5,0x12345000; srai x1,x1,3 → 0x123452B7, 0x4030D093.
- `im_wready` low for 3 cycles during RUN → `cmd_ready` low, `im_wdata` held, and no command is lost or duplicated.
- `base_addr`=2^AW−4 with 2 commands → second write at address 0.
- With `ASM_CHECK_EN`: addi imm 4096 → NOP written and `err`=1, cleared on the next `start`. Reset asserted mid-RUN → all outputs return to 0.

Source files
------------

// File: rtl/inst_asm_loader.sv
// inst_asm_loader: RV32I instruction assembler and instruction-memory loader.
// Symbolic commands arrive over a valid/ready handshake. Each command is
// packed into a 32-bit RV32I word and written to consecutive word addresses.
// Optional build macro ASM_CHECK_EN: when it is defined, out-of-range or
// illegal commands are written as a NOP and raise a sticky err flag.
module inst_asm_loader #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_mn,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [31:0]   cmd_imm,
  input  logic          cmd_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  input  logic          im_wready,
  output logic [AW-2:0] count,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,  MN_SUB   = 5'd1,  MN_XOR  = 5'd2,  MN_OR   = 5'd3,
    MN_AND  = 5'd4,  MN_SLL   = 5'd5,  MN_SRL  = 5'd6,  MN_SRA  = 5'd7,
    MN_SLT  = 5'd8,  MN_SLTU  = 5'd9,  MN_ADDI = 5'd10, MN_XORI = 5'd11,
    MN_ORI  = 5'd12, MN_ANDI  = 5'd13, MN_SLLI = 5'd14, MN_SRLI = 5'd15,
    MN_SRAI = 5'd16, MN_SLTI  = 5'd17, MN_SLTIU = 5'd18, MN_LW  = 5'd19,
    MN_SW   = 5'd20, MN_BEQ   = 5'd21, MN_BNE  = 5'd22, MN_BLT  = 5'd23,
    MN_BGE  = 5'd24, MN_BLTU  = 5'd25, MN_BGEU = 5'd26, MN_LUI  = 5'd27,
    MN_JAL  = 5'd28, MN_JALR  = 5'd29
  } mn_t;

  typedef enum logic [3:0] {
    F_R, F_I, F_SH, F_LD, F_ST, F_B, F_U, F_J, F_JR, F_ILL
  } fmt_t;

  state_t      state;
  fmt_t        fmt;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] enc_word;
  logic [31:0] word;
  logic        bad;
  logic        acc;
  logic        wr_fire;

  assign cmd_ready = (state == RUN) && (!im_we || im_wready);
  assign acc       = cmd_valid && cmd_ready;
  assign wr_fire   = im_we && im_wready;

  // Classify the mnemonic into an instruction format plus funct3 and the bit-30 flag
  always_comb begin
    fmt = F_ILL;
    f3  = 3'b000;
    alt = 1'b0;
    case (mn_t'(cmd_mn))
      MN_ADD:   begin fmt = F_R;  f3 = 3'b000; end
      MN_SUB:   begin fmt = F_R;  f3 = 3'b000; alt = 1'b1; end
      MN_XOR:   begin fmt = F_R;  f3 = 3'b100; end
      MN_OR:    begin fmt = F_R;  f3 = 3'b110; end
      MN_AND:   begin fmt = F_R;  f3 = 3'b111; end
      MN_SLL:   begin fmt = F_R;  f3 = 3'b001; end
      MN_SRL:   begin fmt = F_R;  f3 = 3'b101; end
      MN_SRA:   begin fmt = F_R;  f3 = 3'b101; alt = 1'b1; end
      MN_SLT:   begin fmt = F_R;  f3 = 3'b010; end
      MN_SLTU:  begin fmt = F_R;  f3 = 3'b011; end
      MN_ADDI:  begin fmt = F_I;  f3 = 3'b000; end
      MN_XORI:  begin fmt = F_I;  f3 = 3'b100; end
      MN_ORI:   begin fmt = F_I;  f3 = 3'b110; end
      MN_ANDI:  begin fmt = F_I;  f3 = 3'b111; end
      MN_SLLI:  begin fmt = F_SH; f3 = 3'b001; end
      MN_SRLI:  begin fmt = F_SH; f3 = 3'b101; end
      MN_SRAI:  begin fmt = F_SH; f3 = 3'b101; alt = 1'b1; end
      MN_SLTI:  begin fmt = F_I;  f3 = 3'b010; end
      MN_SLTIU: begin fmt = F_I;  f3 = 3'b011; end
      MN_LW:    begin fmt = F_LD; f3 = 3'b010; end
      MN_SW:    begin fmt = F_ST; f3 = 3'b010; end
      MN_BEQ:   begin fmt = F_B;  f3 = 3'b000; end
      MN_BNE:   begin fmt = F_B;  f3 = 3'b001; end
      MN_BLT:   begin fmt = F_B;  f3 = 3'b100; end
      MN_BGE:   begin fmt = F_B;  f3 = 3'b101; end
      MN_BLTU:  begin fmt = F_B;  f3 = 3'b110; end
      MN_BGEU:  begin fmt = F_B;  f3 = 3'b111; end
      MN_LUI:   begin fmt = F_U;  end
      MN_JAL:   begin fmt = F_J;  end
      MN_JALR:  begin fmt = F_JR; f3 = 3'b000; end
      default:  begin fmt = F_ILL; end
    endcase
  end

  // Pack the fields of the classified format into the RV32I word
  always_comb begin
    enc_word = '0;
    case (fmt)
      F_R:  enc_word = {alt ? 7'b0100000 : 7'b0000000, cmd_rs2, cmd_rs1, f3, cmd_rd, 7'b0110011};
      F_I:  enc_word = {cmd_imm[11:0], cmd_rs1, f3, cmd_rd, 7'b0010011};
      F_SH: enc_word = {alt ? 7'b0100000 : 7'b0000000, cmd_imm[4:0], cmd_rs1, f3, cmd_rd, 7'b0010011};
      F_LD: enc_word = {cmd_imm[11:0], cmd_rs1, f3, cmd_rd, 7'b0000011};
      F_ST: enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, f3, cmd_imm[4:0], 7'b0100011};
      F_B:  enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, f3,
                        cmd_imm[4:1], cmd_imm[11], 7'b1100011};
      F_U:  enc_word = {cmd_imm[31:12], cmd_rd, 7'b0110111};
      F_J:  enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                        cmd_rd, 7'b1101111};
      F_JR: enc_word = {cmd_imm[11:0], cmd_rs1, f3, cmd_rd, 7'b1100111};
      default: enc_word = '0;
    endcase
  end

`ifdef ASM_CHECK_EN
  // Range-check the immediate for the selected format; offenders become a NOP
  always_comb begin
    bad = 1'b0;
    case (fmt)
      F_I, F_LD, F_ST, F_JR: bad = !((&cmd_imm[31:11]) || !(|cmd_imm[31:11]));
      F_SH:  bad = |cmd_imm[31:5];
      F_B:   bad = cmd_imm[0] || !((&cmd_imm[31:12]) || !(|cmd_imm[31:12]));
      F_J:   bad = cmd_imm[0] || !((&cmd_imm[31:20]) || !(|cmd_imm[31:20]));
      F_U:   bad = |cmd_imm[11:0];
      F_ILL: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    word = bad ? 32'h0000_0013 : enc_word;
  end

  // Sticky error flag, cleared when a new session starts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (acc && bad) begin
      err <= 1'b1;
    end
  end
`else
  assign bad  = 1'b0;
  assign word = enc_word;
  assign err  = bad;
`endif

  // Session FSM with the single-entry output register and address/count tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_fire) begin
        im_addr <= im_addr + AW'(4);
        count   <= count + (AW-1)'(1);
      end
      // A same-edge accept keeps im_we high and overwrites the completed word
      if (acc) begin
        im_wdata <= word;
        im_we    <= 1'b1;
      end else if (wr_fire) begin
        im_we <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            im_addr <= {base_addr[AW-1:2], 2'b00};
            count   <= '0;
          end
        end
        RUN: begin
          if (acc && cmd_last) state <= DRAIN;
        end
        DRAIN: begin
          if (wr_fire) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
